// File: rtl/proc_scycle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_scycle_pkg
// Brief    : Shared encodings, control types and immediate helper for the
//            single-cycle TinyRV1 core.
// Revision : 1.0 - initial release
// ============================================================================
package proc_scycle_pkg;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    localparam logic [2:0] c_f3_add   = 3'b000;
    localparam logic [2:0] c_f3_word  = 3'b010;
    localparam logic [2:0] c_f3_jalr  = 3'b000;
    localparam logic [2:0] c_f3_bne   = 3'b001;
    localparam logic [2:0] c_f3_csrrw = 3'b001;
    localparam logic [2:0] c_f3_csrrs = 3'b010;

    localparam logic [6:0] c_f7_add = 7'b0000000;
    localparam logic [6:0] c_f7_mul = 7'b0000001;

    localparam logic [11:0] c_csr_in0  = 12'hFC2;
    localparam logic [11:0] c_csr_in1  = 12'hFC3;
    localparam logic [11:0] c_csr_in2  = 12'hFC4;
    localparam logic [11:0] c_csr_out0 = 12'h7C2;
    localparam logic [11:0] c_csr_out1 = 12'h7C3;
    localparam logic [11:0] c_csr_out2 = 12'h7C4;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_type_e;
    typedef enum logic [1:0] {ALU_ADD, ALU_MUL} alu_op_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;

    typedef struct packed {
        logic      rf_wen;
        logic      op2_imm;
        imm_type_e imm_type;
        alu_op_e   alu_op;
        wb_sel_e   wb_sel;
        logic      mem_val;
        logic      mem_wr;
        logic      is_bne;
        logic      is_jal;
        logic      is_jalr;
        logic      csr_wr;
    } ctrl_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_type_e sel);
        logic [31:0] imm;
        case (sel)
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = {{20{inst[31]}}, inst[31:20]};
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_scycle_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w
// Brief    : 32x32 register file, two combinational reads, one clocked write;
//            x0 reads as zero and ignores writes. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w (
    input  logic        clk,
    input  logic [4:0]  i_rd_addr0,
    output logic [31:0] o_rd_data0,
    input  logic [4:0]  i_rd_addr1,
    output logic [31:0] o_rd_data1,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);

    logic [31:0] r_regs [0:31];

    always_ff @(posedge clk) begin
        if (i_wr_en && (i_wr_addr != 5'd0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data0 = (i_rd_addr0 == 5'd0) ? 32'd0 : r_regs[i_rd_addr0];
    assign o_rd_data1 = (i_rd_addr1 == 5'd0) ? 32'd0 : r_regs[i_rd_addr1];

endmodule
`default_nettype wire

// File: rtl/proc_scycle.sv
`default_nettype none
// ============================================================================
// Module   : proc_scycle
// Brief    : Single-cycle TinyRV1 core: control decoder plus datapath, one
//            instruction retired per clock, with CSR I/O and retire trace.
// Revision : 1.0 - initial release
// ============================================================================
module proc_scycle
    import proc_scycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        imemreq_val,
    output logic [31:0] imemreq_addr,
    input  logic [31:0] imemresp_data,
    output logic        dmemreq_val,
    output logic        dmemreq_type,
    output logic [31:0] dmemreq_addr,
    output logic [31:0] dmemreq_wdata,
    input  logic [31:0] dmemresp_rdata,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic        trace_val,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    logic [31:0] r_pc;
    logic [31:0] r_out0, r_out1, r_out2;

    logic [31:0] w_inst;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [11:0] w_csr;
    ctrl_t       w_ctrl;
    logic        w_csr_rd_hit, w_csr_wr_hit;
    logic [31:0] w_csr_rdata;
    logic [31:0] w_rs1_data, w_rs2_data, w_imm, w_op2, w_alu;
    logic [31:0] w_pc_plus4, w_pc_imm, w_next_pc, w_wb_data;
    logic        w_rf_wen;

    assign w_inst   = imemresp_data;
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_funct3 = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_funct7 = w_inst[31:25];
    assign w_csr    = w_inst[31:20];

    always_comb begin
        w_csr_rd_hit = 1'b1;
        w_csr_rdata  = 32'd0;
        case (w_csr)
            c_csr_in0: w_csr_rdata = in0;
            c_csr_in1: w_csr_rdata = in1;
            c_csr_in2: w_csr_rdata = in2;
            default:   w_csr_rd_hit = 1'b0;
        endcase
    end

    assign w_csr_wr_hit = (w_csr == c_csr_out0) || (w_csr == c_csr_out1) || (w_csr == c_csr_out2);

    // Control decoder: anything not matched falls out as an all-zero nop.
    always_comb begin
        w_ctrl.rf_wen   = 1'b0;
        w_ctrl.op2_imm  = 1'b0;
        w_ctrl.imm_type = IMM_I;
        w_ctrl.alu_op   = ALU_ADD;
        w_ctrl.wb_sel   = WB_ALU;
        w_ctrl.mem_val  = 1'b0;
        w_ctrl.mem_wr   = 1'b0;
        w_ctrl.is_bne   = 1'b0;
        w_ctrl.is_jal   = 1'b0;
        w_ctrl.is_jalr  = 1'b0;
        w_ctrl.csr_wr   = 1'b0;
        case (w_opcode)
            c_opc_op: begin
                if (w_funct3 == c_f3_add && w_funct7 == c_f7_add) begin
                    w_ctrl.rf_wen = 1'b1;
                end else if (w_funct3 == c_f3_add && w_funct7 == c_f7_mul) begin
                    w_ctrl.rf_wen = 1'b1;
                    w_ctrl.alu_op = ALU_MUL;
                end
            end
            c_opc_opimm: begin
                if (w_funct3 == c_f3_add) begin
                    w_ctrl.rf_wen  = 1'b1;
                    w_ctrl.op2_imm = 1'b1;
                end
            end
            c_opc_load: begin
                if (w_funct3 == c_f3_word) begin
                    w_ctrl.rf_wen  = 1'b1;
                    w_ctrl.op2_imm = 1'b1;
                    w_ctrl.wb_sel  = WB_MEM;
                    w_ctrl.mem_val = 1'b1;
                end
            end
            c_opc_store: begin
                if (w_funct3 == c_f3_word) begin
                    w_ctrl.op2_imm  = 1'b1;
                    w_ctrl.imm_type = IMM_S;
                    w_ctrl.mem_val  = 1'b1;
                    w_ctrl.mem_wr   = 1'b1;
                end
            end
            c_opc_jal: begin
                w_ctrl.rf_wen   = 1'b1;
                w_ctrl.imm_type = IMM_J;
                w_ctrl.wb_sel   = WB_PC4;
                w_ctrl.is_jal   = 1'b1;
            end
            c_opc_jalr: begin
                if (w_funct3 == c_f3_jalr) begin
                    w_ctrl.rf_wen  = 1'b1;
                    w_ctrl.op2_imm = 1'b1;
                    w_ctrl.wb_sel  = WB_PC4;
                    w_ctrl.is_jalr = 1'b1;
                end
            end
            c_opc_branch: begin
                if (w_funct3 == c_f3_bne) begin
                    w_ctrl.imm_type = IMM_B;
                    w_ctrl.is_bne   = 1'b1;
                end
            end
            c_opc_system: begin
                if (w_funct3 == c_f3_csrrs && w_csr_rd_hit) begin
                    w_ctrl.rf_wen = 1'b1;
                    w_ctrl.wb_sel = WB_CSR;
                end else if (w_funct3 == c_f3_csrrw && w_csr_wr_hit) begin
                    w_ctrl.csr_wr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    regfile_2r1w u_regfile (
        .clk        (clk),
        .i_rd_addr0 (w_rs1),
        .o_rd_data0 (w_rs1_data),
        .i_rd_addr1 (w_rs2),
        .o_rd_data1 (w_rs2_data),
        .i_wr_en    (w_rf_wen),
        .i_wr_addr  (w_rd),
        .i_wr_data  (w_wb_data)
    );

    assign w_imm      = gen_imm(w_inst, w_ctrl.imm_type);
    assign w_op2      = w_ctrl.op2_imm ? w_imm : w_rs2_data;
    assign w_alu      = (w_ctrl.alu_op == ALU_MUL) ? (w_rs1_data * w_op2) : (w_rs1_data + w_op2);
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_imm   = r_pc + w_imm;

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_ctrl.is_jal) begin
            w_next_pc = w_pc_imm;
        end else if (w_ctrl.is_jalr) begin
            w_next_pc = {w_alu[31:1], 1'b0};
        end else if (w_ctrl.is_bne && (w_rs1_data != w_rs2_data)) begin
            w_next_pc = w_pc_imm;
        end
    end

    always_comb begin
        case (w_ctrl.wb_sel)
            WB_MEM:  w_wb_data = dmemresp_rdata;
            WB_PC4:  w_wb_data = w_pc_plus4;
            WB_CSR:  w_wb_data = w_csr_rdata;
            default: w_wb_data = w_alu;
        endcase
    end

    // Nothing architectural may change while rst is held.
    assign w_rf_wen = w_ctrl.rf_wen && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= 32'd0;
            r_out0 <= 32'd0;
            r_out1 <= 32'd0;
            r_out2 <= 32'd0;
        end else begin
            r_pc <= w_next_pc;
            if (w_ctrl.csr_wr) begin
                if (w_csr == c_csr_out0) r_out0 <= w_rs1_data;
                if (w_csr == c_csr_out1) r_out1 <= w_rs1_data;
                if (w_csr == c_csr_out2) r_out2 <= w_rs1_data;
            end
        end
    end

    assign imemreq_val   = !rst;
    assign imemreq_addr  = r_pc;
    assign dmemreq_val   = w_ctrl.mem_val && !rst;
    assign dmemreq_type  = w_ctrl.mem_wr;
    assign dmemreq_addr  = w_alu;
    assign dmemreq_wdata = w_rs2_data;
    assign out0          = r_out0;
    assign out1          = r_out1;
    assign out2          = r_out2;
    assign trace_val     = !rst;
    assign trace_addr    = r_pc;
    assign trace_data    = (w_rf_wen && (w_rd != 5'd0)) ? w_wb_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_proc_scycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_scycle
// Brief    : Self-checking bench: directed program table, mid-run reset and
//            random programs compared against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_proc_scycle;

    localparam logic [31:0] c_nop = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemreq_val, dmemreq_val, dmemreq_type, trace_val;
    logic [31:0] imemreq_addr, imemresp_data, dmemreq_addr, dmemreq_wdata, dmemresp_rdata;
    logic [31:0] in0 = '0, in1 = '0, in2 = '0;
    logic [31:0] out0, out1, out2, trace_addr, trace_data;

    logic [31:0] imem [0:1023];
    logic [31:0] dmem [0:1023];

    int n_cmp  = 0;
    int n_fail = 0;

    // Instruction-level model state
    logic [31:0] m_pc;
    logic [31:0] m_rf   [0:31];
    logic [31:0] m_dmem [0:1023];
    logic [31:0] m_out  [0:2];
    logic [31:0] m_in   [0:2];

    always #5 clk = ~clk;

    assign imemresp_data  = imem[imemreq_addr[11:2]];
    assign dmemresp_rdata = dmem[dmemreq_addr[11:2]];

    proc_scycle dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
        .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
        .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
        .in0(in0), .in1(in1), .in2(in2), .out0(out0), .out1(out1), .out2(out2),
        .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data)
    );

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] asm_addi(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'h13);
    endfunction
    function automatic logic [31:0] asm_add(logic [4:0] rd, logic [4:0] a, logic [4:0] b);
        return enc_r(7'd0, b, a, 3'd0, rd, 7'h33);
    endfunction
    function automatic logic [31:0] asm_mul(logic [4:0] rd, logic [4:0] a, logic [4:0] b);
        return enc_r(7'd1, b, a, 3'd0, rd, 7'h33);
    endfunction
    function automatic logic [31:0] asm_lw(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
        return enc_i(imm, rs1, 3'd2, rd, 7'h03);
    endfunction
    function automatic logic [31:0] asm_sw(logic [4:0] rs2, logic [4:0] rs1, logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] asm_bne(logic [4:0] a, logic [4:0] b, logic [31:0] imm);
        return {imm[12], imm[10:5], b, a, 3'd1, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] asm_jal(logic [4:0] rd, logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] asm_jr(logic [4:0] rs1);
        return enc_i(32'd0, rs1, 3'd0, 5'd0, 7'h67);
    endfunction
    function automatic logic [31:0] asm_csrr(logic [4:0] rd, logic [31:0] csr);
        return enc_i(csr, 5'd0, 3'd2, rd, 7'h73);
    endfunction
    function automatic logic [31:0] asm_csrw(logic [31:0] csr, logic [4:0] rs1);
        return enc_i(csr, rs1, 3'd1, 5'd0, 7'h73);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Finish the current cycle, emulating the data memory's clocked write.
    task automatic tick();
        logic        we;
        logic [31:0] wa, wd;
        we = dmemreq_val && dmemreq_type;
        wa = dmemreq_addr;
        wd = dmemreq_wdata;
        @(posedge clk);
        if (we) dmem[wa[11:2]] = wd;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with rst low.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " rst imemreq_val"}, {31'd0, imemreq_val}, 32'd0);
        chk({tag, " rst dmemreq_val"}, {31'd0, dmemreq_val}, 32'd0);
        chk({tag, " rst trace_val"},   {31'd0, trace_val},   32'd0);
        chk({tag, " rst pc"},          imemreq_addr,         32'd0);
        chk({tag, " rst out0"},        out0,                 32'd0);
        chk({tag, " rst out1"},        out1,                 32'd0);
        chk({tag, " rst out2"},        out2,                 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'd0;
        for (int k = 0; k < 3; k++) m_out[k] = 32'd0;
    endtask

    task automatic load_prog_clear();
        for (int k = 0; k < 1024; k++) imem[k] = c_nop;
    endtask

    // Instruction-set model: one architectural step from the program image.
    task automatic iss_step(output logic [31:0] ea, output logic [31:0] ed);
        logic [31:0] ins, a, b, ii, is_, ib, ij, npc, wv, ad;
        logic        wen;
        logic [4:0]  rd;
        int          csr;
        ins = imem[m_pc[11:2]];
        rd  = ins[11:7];
        a   = m_rf[ins[19:15]];
        b   = m_rf[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        csr = int'(ins[31:20]);
        npc = m_pc + 4;
        wen = 1'b0;
        wv  = 32'd0;
        case (ins[6:0])
            7'h33: if (ins[14:12] == 3'd0 && ins[31:25] == 7'd0) begin wen = 1; wv = a + b; end
                   else if (ins[14:12] == 3'd0 && ins[31:25] == 7'd1) begin wen = 1; wv = a * b; end
            7'h13: if (ins[14:12] == 3'd0) begin wen = 1; wv = a + ii; end
            7'h03: if (ins[14:12] == 3'd2) begin ad = a + ii; wen = 1; wv = m_dmem[ad[11:2]]; end
            7'h23: if (ins[14:12] == 3'd2) begin ad = a + is_; m_dmem[ad[11:2]] = b; end
            7'h6F: begin wen = 1; wv = m_pc + 4; npc = m_pc + ij; end
            7'h67: if (ins[14:12] == 3'd0) begin wen = 1; wv = m_pc + 4; npc = (a + ii) & ~32'd1; end
            7'h63: if (ins[14:12] == 3'd1 && a != b) npc = m_pc + ib;
            7'h73: begin
                if (ins[14:12] == 3'd2 && csr >= 'hFC2 && csr <= 'hFC4) begin
                    wen = 1; wv = m_in[csr - 'hFC2];
                end else if (ins[14:12] == 3'd1 && csr >= 'h7C2 && csr <= 'h7C4) begin
                    m_out[csr - 'h7C2] = a;
                end
            end
            default: ;
        endcase
        ea = m_pc;
        ed = (wen && rd != 5'd0) ? wv : 32'd0;
        if (wen && rd != 5'd0) m_rf[rd] = wv;
        m_pc = npc;
    endtask

    typedef struct packed {
        logic [31:0]       in0, in1, in2;
        logic [7:0][31:0]  prog;
        logic [3:0]        ncyc;
        logic [7:0][31:0]  exp_addr;
        logic [7:0][31:0]  exp_data;
        logic [2:0][31:0]  exp_out;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] ea, ed;
        for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
        for (int k = 0; k < 1024; k++) begin dmem[k] = 32'd0; m_dmem[k] = 32'd0; end
        for (int v = 0; v < 6; v++) vecs[v] = '0;

        // CSR basic
        vecs[0].in0 = 32'h5;
        vecs[0].prog[0] = asm_csrr(5'd1, 32'hFC2);
        vecs[0].prog[1] = asm_csrw(32'h7C2, 5'd1);
        vecs[0].ncyc = 4'd2;
        vecs[0].exp_addr[1] = 32'h4;
        vecs[0].exp_data[0] = 32'h5;
        vecs[0].exp_out[0]  = 32'h5;
        // All I/O
        vecs[1].in0 = 32'd1; vecs[1].in1 = 32'd2; vecs[1].in2 = 32'd3;
        vecs[1].prog[0] = asm_csrr(5'd1, 32'hFC2);
        vecs[1].prog[1] = asm_csrr(5'd2, 32'hFC3);
        vecs[1].prog[2] = asm_csrr(5'd3, 32'hFC4);
        vecs[1].prog[3] = asm_csrw(32'h7C4, 5'd1);
        vecs[1].prog[4] = asm_csrw(32'h7C3, 5'd2);
        vecs[1].prog[5] = asm_csrw(32'h7C2, 5'd3);
        vecs[1].ncyc = 4'd6;
        for (int c = 0; c < 6; c++) vecs[1].exp_addr[c] = 32'(4 * c);
        vecs[1].exp_data[0] = 32'd1; vecs[1].exp_data[1] = 32'd2; vecs[1].exp_data[2] = 32'd3;
        vecs[1].exp_out[0] = 32'd3; vecs[1].exp_out[1] = 32'd2; vecs[1].exp_out[2] = 32'd1;
        // Arithmetic
        vecs[2].prog[0] = asm_addi(5'd1, 5'd0, 32'd7);
        vecs[2].prog[1] = asm_addi(5'd2, 5'd0, -32'sd3);
        vecs[2].prog[2] = asm_add(5'd3, 5'd1, 5'd2);
        vecs[2].prog[3] = asm_mul(5'd4, 5'd1, 5'd2);
        vecs[2].ncyc = 4'd4;
        for (int c = 0; c < 4; c++) vecs[2].exp_addr[c] = 32'(4 * c);
        vecs[2].exp_data[0] = 32'd7; vecs[2].exp_data[1] = 32'hFFFFFFFD;
        vecs[2].exp_data[2] = 32'd4; vecs[2].exp_data[3] = 32'hFFFFFFEB;
        // Memory (0x100 preloaded with 0xDEF)
        vecs[3].prog[0] = asm_addi(5'd1, 5'd0, 32'h100);
        vecs[3].prog[1] = asm_lw(5'd2, 5'd1, 32'd0);
        vecs[3].prog[2] = asm_sw(5'd2, 5'd1, 32'd4);
        vecs[3].prog[3] = asm_lw(5'd3, 5'd1, 32'd4);
        vecs[3].ncyc = 4'd4;
        for (int c = 0; c < 4; c++) vecs[3].exp_addr[c] = 32'(4 * c);
        vecs[3].exp_data[0] = 32'h100; vecs[3].exp_data[1] = 32'hDEF; vecs[3].exp_data[3] = 32'hDEF;
        // Control flow: bne taken, jal, jr, bne not taken
        vecs[4].prog[0] = asm_addi(5'd1, 5'd0, 32'd5);
        vecs[4].prog[1] = asm_addi(5'd2, 5'd0, 32'd6);
        vecs[4].prog[2] = asm_bne(5'd1, 5'd2, 32'd8);
        vecs[4].prog[3] = asm_addi(5'd5, 5'd0, 32'd1);
        vecs[4].prog[4] = asm_jal(5'd1, 32'd8);
        vecs[4].prog[5] = asm_bne(5'd1, 5'd1, -32'sd20);
        vecs[4].prog[6] = asm_jr(5'd1);
        vecs[4].ncyc = 4'd7;
        vecs[4].exp_addr[1] = 32'h04; vecs[4].exp_addr[2] = 32'h08; vecs[4].exp_addr[3] = 32'h10;
        vecs[4].exp_addr[4] = 32'h18; vecs[4].exp_addr[5] = 32'h14; vecs[4].exp_addr[6] = 32'h18;
        vecs[4].exp_data[0] = 32'd5; vecs[4].exp_data[1] = 32'd6; vecs[4].exp_data[3] = 32'h14;
        // Unknown CSRs, illegal opcode, write to x0
        vecs[5].in0 = 32'h11;
        vecs[5].prog[0] = asm_addi(5'd1, 5'd0, 32'd3);
        vecs[5].prog[1] = asm_csrr(5'd2, 32'h123);
        vecs[5].prog[2] = asm_csrw(32'h7C5, 5'd1);
        vecs[5].prog[3] = 32'h0000000B;
        vecs[5].prog[4] = asm_csrw(32'h7C3, 5'd1);
        vecs[5].prog[5] = asm_addi(5'd0, 5'd0, 32'd5);
        vecs[5].ncyc = 4'd6;
        for (int c = 0; c < 6; c++) vecs[5].exp_addr[c] = 32'(4 * c);
        vecs[5].exp_data[0] = 32'd3;
        vecs[5].exp_out[1]  = 32'd3;

        for (int v = 0; v < 6; v++) begin
            load_prog_clear();
            for (int k = 0; k < 8; k++) imem[k] = vecs[v].prog[k];
            dmem[64] = 32'h00000DEF;
            dmem[65] = 32'd0;
            in0 = vecs[v].in0; in1 = vecs[v].in1; in2 = vecs[v].in2;
            do_reset($sformatf("v%0d", v));
            for (int c = 0; c < int'(vecs[v].ncyc); c++) begin
                #1;
                chk($sformatf("v%0d c%0d trace_val", v, c), {31'd0, trace_val}, 32'd1);
                chk($sformatf("v%0d c%0d trace_addr", v, c), trace_addr, vecs[v].exp_addr[c]);
                chk($sformatf("v%0d c%0d trace_data", v, c), trace_data, vecs[v].exp_data[c]);
                tick();
            end
            chk($sformatf("v%0d out0", v), out0, vecs[v].exp_out[0]);
            chk($sformatf("v%0d out1", v), out1, vecs[v].exp_out[1]);
            chk($sformatf("v%0d out2", v), out2, vecs[v].exp_out[2]);
        end

        // Reset in the middle of a running program
        load_prog_clear();
        for (int k = 0; k < 8; k++) imem[k] = vecs[1].prog[k];
        in0 = 32'd1; in1 = 32'd2; in2 = 32'd3;
        do_reset("mid pre");
        for (int c = 0; c < 4; c++) tick();
        chk("mid out2 before reset", out2, 32'd1);
        do_reset("mid");
        #1;
        chk("mid restart trace_val", {31'd0, trace_val}, 32'd1);
        chk("mid restart trace_addr", trace_addr, 32'd0);
        chk("mid restart trace_data", trace_data, 32'd1);
        tick();

        // Random programs against the instruction-level model
        for (int run = 0; run < 3; run++) begin
            logic [31:0] csr_rd [5];
            logic [31:0] csr_wr [4];
            csr_rd = '{32'hFC2, 32'hFC3, 32'hFC4, 32'h7C2, 32'hFC5};
            csr_wr = '{32'h7C2, 32'h7C3, 32'h7C4, 32'hFC2};
            load_prog_clear();
            for (int r = 1; r < 8; r++) imem[r - 1] = asm_addi(5'(r), 5'd0, 32'($urandom_range(0, 4095)));
            imem[7] = asm_addi(5'd31, 5'd0, 32'h200);
            for (int i = 8; i < 48; i++) begin
                logic [4:0] rd, ra, rb;
                rd = 5'($urandom_range(0, 7));
                ra = 5'($urandom_range(0, 7));
                rb = 5'($urandom_range(0, 7));
                case ($urandom_range(0, 9))
                    0: imem[i] = asm_addi(rd, ra, 32'($urandom_range(0, 4095)));
                    1: imem[i] = asm_add(rd, ra, rb);
                    2: imem[i] = asm_mul(rd, ra, rb);
                    3: imem[i] = asm_lw(rd, 5'd31, 32'(4 * $urandom_range(0, 15)));
                    4: imem[i] = asm_sw(rb, 5'd31, 32'(4 * $urandom_range(0, 15)));
                    5: imem[i] = (i + 3 <= 48) ? asm_bne(ra, rb, 32'(4 * $urandom_range(2, 3)))
                                               : asm_add(rd, ra, rb);
                    6: imem[i] = asm_jal(rd, 32'd8);
                    7: imem[i] = asm_csrr(rd, csr_rd[$urandom_range(0, 4)]);
                    8: imem[i] = asm_csrw(csr_wr[$urandom_range(0, 3)], ra);
                    default: imem[i] = {$urandom() & 32'hFFFFFF80} | 32'h0000000B;
                endcase
            end
            imem[48] = asm_jal(5'd0, 32'd0);
            for (int k = 128; k < 144; k++) begin
                dmem[k]   = $urandom();
                m_dmem[k] = dmem[k];
            end
            in0 = $urandom(); in1 = $urandom(); in2 = $urandom();
            m_in[0] = in0; m_in[1] = in1; m_in[2] = in2;
            do_reset($sformatf("rnd%0d", run));
            for (int c = 0; c < 60; c++) begin
                #1;
                chk($sformatf("rnd%0d c%0d out0", run, c), out0, m_out[0]);
                chk($sformatf("rnd%0d c%0d out1", run, c), out1, m_out[1]);
                chk($sformatf("rnd%0d c%0d out2", run, c), out2, m_out[2]);
                iss_step(ea, ed);
                chk($sformatf("rnd%0d c%0d trace_val", run, c), {31'd0, trace_val}, 32'd1);
                chk($sformatf("rnd%0d c%0d trace_addr", run, c), trace_addr, ea);
                chk($sformatf("rnd%0d c%0d trace_data", run, c), trace_data, ed);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
